// File: rtl/pid_sched_pkg.sv
// pid_sched_pkg
//   Shared definitions for the PID step scheduler: FSM state encoding,
//   default geometry (channel count, datapath latency, data width) and a
//   small helper that classifies states as "step in progress".
package pid_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_COMMIT,
        ST_DONE
    } sched_state_t;

    // Default latency matches the multiplier + adder pipeline of the datapath.
    localparam int DEF_N_CH = 8;
    localparam int DEF_LAT  = 19;
    localparam int DEF_W    = 64;

    // A new step_start is refused (and flagged) in these states.
    function automatic logic is_busy(input sched_state_t s);
        return (s == ST_SCAN) || (s == ST_DRAIN) || (s == ST_COMMIT);
    endfunction

endpackage

// File: rtl/pid_step_scheduler_if.sv
// pid_step_scheduler_if
//   Bundles every non-clock signal between the scheduler and its
//   environment (step timer, input RAM, datapath, result RAM).
//   master : scheduler side  (drives reads, operands, writes, status)
//   slave  : environment side (drives step requests, RAM data, results)
interface pid_step_scheduler_if
    import pid_sched_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int W    = DEF_W
);
    localparam int CH_W = $clog2(N_CH);

    logic            step_start;
    logic [N_CH-1:0] en_mask;
    logic            x_rd_en;
    logic [CH_W-1:0] x_rd_addr;
    logic [W-1:0]    x_rd_data;
    logic            dp_valid;
    logic [W-1:0]    dp_x;
    logic [W-1:0]    dp_y;
    logic            dp_done;
    logic            y_wr_en;
    logic [CH_W-1:0] y_wr_addr;
    logic [W-1:0]    y_wr_data;
    logic            commit;
    logic            step_done;
    logic            busy;
    logic            overrun;
    logic            seq_err;

    modport master (
        input  step_start, en_mask, x_rd_data, dp_y, dp_done,
        output x_rd_en, x_rd_addr, dp_valid, dp_x, y_wr_en, y_wr_addr,
               y_wr_data, commit, step_done, busy, overrun, seq_err
    );

    modport slave (
        output step_start, en_mask, x_rd_data, dp_y, dp_done,
        input  x_rd_en, x_rd_addr, dp_valid, dp_x, y_wr_en, y_wr_addr,
               y_wr_data, commit, step_done, busy, overrun, seq_err
    );

endinterface

// File: rtl/pid_tag_pipe.sv
// pid_tag_pipe
//   LAT-deep shift register of {valid, channel} tags that mirrors the
//   datapath pipeline, so the tag leaving the head lines up with the
//   datapath result of the same operand. Requires LAT >= 2.
//   clk, rst   : clock, synchronous clear of the valid bits
//   in_vld/ch  : tag entering alongside dp_valid
//   head_vld/ch: tag aligned with dp_done/dp_y
//   body_busy  : some valid tag is still in flight behind the head
module pid_tag_pipe
    import pid_sched_pkg::*;
#(
    parameter int LAT  = DEF_LAT,
    parameter int CH_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    input  logic [CH_W-1:0] in_ch,
    output logic            head_vld,
    output logic [CH_W-1:0] head_ch,
    output logic            body_busy
);

    logic [LAT-1:0]  vld_line;
    logic [CH_W-1:0] ch_line [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_line <= '0;
        end else begin
            vld_line <= {vld_line[LAT-2:0], in_vld};
        end
    end

    // Channel tags only matter under a set valid bit, so they are not cleared.
    always_ff @(posedge clk) begin
        ch_line[0] <= in_ch;
        for (int i = 1; i < LAT; i++) begin
            ch_line[i] <= ch_line[i-1];
        end
    end

    assign head_vld  = vld_line[LAT-1];
    assign head_ch   = ch_line[LAT-1];
    assign body_busy = |vld_line[LAT-2:0];

endmodule

// File: rtl/pid_step_scheduler.sv
// pid_step_scheduler
//   Time-multiplexes one fixed-latency datapath across N_CH channels per
//   simulation step: scans the input RAM, issues one operand per cycle,
//   writes returning results by tag, then pulses commit and step_done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : master side of pid_step_scheduler_if (step request, input
//              RAM read port, datapath operand/result, result RAM write
//              port, commit/step_done strobes, busy and sticky error flags)
module pid_step_scheduler
    import pid_sched_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int LAT  = DEF_LAT,
    parameter int W    = DEF_W,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    pid_step_scheduler_if.master  bus
);

    sched_state_t    state, state_nx;
    logic [CH_W-1:0] cnt;
    logic [N_CH-1:0] mask_r;
    logic            rd_en;
    logic            commit_o;
    logic            done_o;
    logic            accept;

    logic            vld_p0;
    logic [CH_W-1:0] ch_p0;

    logic            head_vld;
    logic [CH_W-1:0] head_ch;
    logic            body_busy;
    logic            seq_mismatch;
    logic            overrun_r;
    logic            seq_err_r;
    logic [W-1:0]    y_data;

    // A step is accepted when idle or in the step_done cycle (back-to-back).
    assign accept = bus.step_start && ((state == ST_IDLE) || (state == ST_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        commit_o = 1'b0;
        done_o   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.step_start) state_nx = ST_SCAN;
            end
            ST_SCAN: begin
                rd_en = mask_r[cnt];
                if (cnt == CH_W'(N_CH - 1)) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The head tag may still be writing this cycle; commit follows it.
                if (!vld_p0 && !body_busy) state_nx = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit_o = 1'b1;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                done_o   = 1'b1;
                state_nx = bus.step_start ? ST_SCAN : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            mask_r    <= '0;
            vld_p0    <= 1'b0;
            overrun_r <= 1'b0;
            seq_err_r <= 1'b0;
        end else begin
            if (accept) begin
                mask_r <= bus.en_mask;
                cnt    <= '0;
            end else if (state == ST_SCAN) begin
                cnt <= cnt + CH_W'(1);
            end
            vld_p0 <= rd_en;
            if (bus.step_start && is_busy(state)) overrun_r <= 1'b1;
            if (seq_mismatch) seq_err_r <= 1'b1;
        end
    end

    // ---- stage p0: operand issue, one cycle after the RAM read ----
    always_ff @(posedge clk) begin
        ch_p0 <= cnt;
    end

    pid_tag_pipe #(
        .LAT  (LAT),
        .CH_W (CH_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (vld_p0),
        .in_ch     (ch_p0),
        .head_vld  (head_vld),
        .head_ch   (head_ch),
        .body_busy (body_busy)
    );

    // ---- tag head: result write-back, aligned with dp_done ----
    assign seq_mismatch = bus.dp_done != head_vld;
    assign y_data       = head_vld ? bus.dp_y : '0;

    assign bus.x_rd_en   = rd_en;
    assign bus.x_rd_addr = (state == ST_SCAN) ? cnt : '0;
    assign bus.dp_valid  = vld_p0;
    assign bus.dp_x      = vld_p0 ? bus.x_rd_data : '0;
    assign bus.y_wr_en   = head_vld;
    assign bus.y_wr_addr = head_vld ? head_ch : '0;
    assign bus.y_wr_data = y_data;
    assign bus.commit    = commit_o;
    assign bus.step_done = done_o;
    assign bus.busy      = is_busy(state);
    assign bus.overrun   = overrun_r;
    // The offending cycle itself already shows the error.
    assign bus.seq_err   = seq_err_r | seq_mismatch;

endmodule

// File: tb/tb_pid_step_scheduler.sv
module tb_pid_step_scheduler;
    import pid_sched_pkg::*;

    localparam int N_CH = 8;
    localparam int LAT  = 19;
    localparam int W    = 64;
    localparam int NTR  = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pid_step_scheduler_if #(.N_CH(N_CH), .W(W)) bus ();

    pid_step_scheduler #(.N_CH(N_CH), .LAT(LAT), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Input RAM contents and a y = x datapath model of latency LAT.
    logic [W-1:0]   xmem [N_CH];
    logic [W-1:0]   dpd  [LAT];
    logic [LAT-1:0] dpv;
    logic           drop_en = 1'b0;

    always @(posedge clk) begin
        if (bus.x_rd_en) bus.x_rd_data <= xmem[bus.x_rd_addr];
    end

    always @(posedge clk) begin
        if (rst) dpv <= '0;
        else     dpv <= {dpv[LAT-2:0], bus.dp_valid};
        dpd[0] <= bus.dp_x;
        for (int i = 1; i < LAT; i++) dpd[i] <= dpd[i-1];
    end

    assign bus.dp_y    = dpd[LAT-1];
    assign bus.dp_done = dpv[LAT-1] && !(drop_en && (dpd[LAT-1] == xmem[3]));

    typedef struct {
        logic         rd_en;
        logic [2:0]   rd_addr;
        logic         dv;
        logic [W-1:0] dx;
        logic         we;
        logic [2:0]   wa;
        logic [W-1:0] wd;
        logic         cm;
        logic         sd;
        logic         bz;
        logic         ov;
        logic         se;
    } smp_t;

    smp_t tr [NTR];

    typedef struct {
        logic [7:0] mask;
        int         com;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic sample(input int c);
        tr[c].rd_en   = bus.x_rd_en;
        tr[c].rd_addr = bus.x_rd_addr;
        tr[c].dv      = bus.dp_valid;
        tr[c].dx      = bus.dp_x;
        tr[c].we      = bus.y_wr_en;
        tr[c].wa      = bus.y_wr_addr;
        tr[c].wd      = bus.y_wr_data;
        tr[c].cm      = bus.commit;
        tr[c].sd      = bus.step_done;
        tr[c].bz      = bus.busy;
        tr[c].ov      = bus.overrun;
        tr[c].se      = bus.seq_err;
    endtask

    // Cycle 0 is the cycle whose closing edge samples step_start.
    // es/em: extra step_start (and mask) in cycle es; rc: rst held in cycle rc.
    task automatic run(input logic [7:0] m, input int es, input logic [7:0] em,
                       input int rc, input int ncyc);
        @(negedge clk);
        bus.step_start = 1'b1;
        bus.en_mask    = m;
        @(negedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            bus.step_start = (c == es);
            bus.en_mask    = (c == es) ? em : 8'h00;
            rst            = (c == rc);
            sample(c);
            @(negedge clk);
        end
        bus.step_start = 1'b0;
        bus.en_mask    = 8'h00;
        rst            = 1'b0;
    endtask

    function automatic smp_t exp_at(input int c, input int o1, input logic [7:0] m1, input int c1,
                                    input int o2, input logic [7:0] m2, input int c2, input int rc);
        smp_t       e;
        int         os [2];
        logic [7:0] ms [2];
        int         cs [2];
        int         r;
        int         k;
        e = '{default: '0};
        os[0] = o1; ms[0] = m1; cs[0] = c1;
        os[1] = o2; ms[1] = m2; cs[1] = c2;
        for (int j = 0; j < 2; j++) begin
            if (os[j] >= 0) begin
                r = c - os[j];
                if (r >= 1 && r <= N_CH) begin
                    if (ms[j][r-1]) begin e.rd_en = 1'b1; e.rd_addr = 3'(r-1); end
                end
                if (r >= 2 && r <= N_CH + 1) begin
                    if (ms[j][r-2]) begin e.dv = 1'b1; e.dx = xmem[r-2]; end
                end
                k = r - 2 - LAT;
                if (k >= 0 && k < N_CH) begin
                    if (ms[j][k]) begin e.we = 1'b1; e.wa = 3'(k); e.wd = xmem[k]; end
                end
                if (r == cs[j])             e.cm = 1'b1;
                if (r == cs[j] + 1)         e.sd = 1'b1;
                if (r >= 1 && r <= cs[j])   e.bz = 1'b1;
            end
        end
        if (rc >= 0 && c > rc) e = '{default: '0};
        return e;
    endfunction

    task automatic check_trace(input string nm, input int ncyc, input logic [7:0] m1, input int c1,
                               input int o2, input logic [7:0] m2, input int c2, input int rc);
        smp_t e;
        int rd_b = 0, dv_b = 0, wr_b = 0, cm_b = 0, sd_b = 0, bz_b = 0;
        for (int c = 1; c <= ncyc; c++) begin
            e = exp_at(c, 0, m1, c1, o2, m2, c2, rc);
            if (tr[c].rd_en !== e.rd_en || (e.rd_en && tr[c].rd_addr !== e.rd_addr)) rd_b++;
            if (tr[c].dv !== e.dv || tr[c].dx !== e.dx) dv_b++;
            if (tr[c].we !== e.we || tr[c].wa !== e.wa || tr[c].wd !== e.wd) wr_b++;
            if (tr[c].cm !== e.cm) cm_b++;
            if (tr[c].sd !== e.sd) sd_b++;
            if (tr[c].bz !== e.bz) bz_b++;
        end
        check({nm, ".read_cycles_off"},   64'(rd_b), 64'd0);
        check({nm, ".issue_cycles_off"},  64'(dv_b), 64'd0);
        check({nm, ".write_cycles_off"},  64'(wr_b), 64'd0);
        check({nm, ".commit_cycles_off"}, 64'(cm_b), 64'd0);
        check({nm, ".done_cycles_off"},   64'(sd_b), 64'd0);
        check({nm, ".busy_cycles_off"},   64'(bz_b), 64'd0);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst            = 1'b1;
        bus.step_start = 1'b0;
        bus.en_mask    = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check({nm, ".ctrl_outs"},
              64'({bus.x_rd_en, bus.dp_valid, bus.y_wr_en, bus.commit, bus.step_done,
                   bus.busy, bus.overrun, bus.seq_err, bus.x_rd_addr, bus.y_wr_addr}), 64'd0);
        check({nm, ".data_outs"}, bus.dp_x | bus.y_wr_data, 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        bus.step_start = 1'b0;
        bus.en_mask    = 8'h00;
        for (int k = 0; k < N_CH; k++) xmem[k] = 64'hC0DE_0000_0000_0000 + 64'(k) * 64'h1_0001;

        tbl[0] = '{8'hFF, 29};
        tbl[1] = '{8'h05, 24};
        tbl[2] = '{8'h00, 10};
        tbl[3] = '{8'h80, 29};
        tbl[4] = '{8'h01, 22};
        tbl[5] = '{8'h40, 28};

        do_reset("reset0");

        foreach (tbl[i]) begin
            run(tbl[i].mask, -1, 8'h00, -1, 34);
            check_trace($sformatf("mask%02h", tbl[i].mask), 34, tbl[i].mask, tbl[i].com,
                        -1, 8'h00, 0, -1);
            check($sformatf("mask%02h.overrun", tbl[i].mask), 64'(tr[34].ov), 64'd0);
            check($sformatf("mask%02h.seq_err", tbl[i].mask), 64'(tr[34].se), 64'd0);
        end

        // Start request while busy: ignored, flagged, timing unchanged.
        run(8'hFF, 5, 8'h00, -1, 34);
        check_trace("overrun", 34, 8'hFF, 29, -1, 8'h00, 0, -1);
        check("overrun.before", 64'(tr[5].ov), 64'd0);
        check("overrun.after",  64'(tr[6].ov), 64'd1);
        check("overrun.sticky", 64'(tr[34].ov), 64'd1);
        do_reset("reset1");

        // Back-to-back start in the step_done cycle (25) is accepted.
        run(8'h05, 25, 8'h01, -1, 50);
        check_trace("b2b", 50, 8'h05, 24, 25, 8'h01, 22, -1);
        check("b2b.overrun", 64'(tr[50].ov), 64'd0);
        do_reset("reset2");

        // Datapath drops the ch3 result strobe (due in cycle 24).
        drop_en = 1'b1;
        run(8'hFF, -1, 8'h00, -1, 34);
        drop_en = 1'b0;
        check_trace("drop", 34, 8'hFF, 29, -1, 8'h00, 0, -1);
        check("drop.seq_err_c23",   64'(tr[23].se), 64'd0);
        check("drop.seq_err_c24",   64'(tr[24].se), 64'd1);
        check("drop.seq_err_stick", 64'(tr[34].se), 64'd1);
        do_reset("reset3");

        // Reset in cycle 15 of a running step, then a nominal step.
        run(8'hFF, -1, 8'h00, 15, 34);
        check_trace("midrst", 34, 8'hFF, 29, -1, 8'h00, 0, 15);
        check("midrst.flags", 64'({tr[16].ov, tr[16].se}), 64'd0);
        run(8'hFF, -1, 8'h00, -1, 34);
        check_trace("postrst", 34, 8'hFF, 29, -1, 8'h00, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
